mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the combinational ALU in the EX stage of the 5-stage MIPS32 pipeline.
- Executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles, and MTHI/MTLO in a single cycle.
- Exposes a start/busy/done handshake so the hazard unit can stall on HI/LO readers (MFHI/MFLO).
- Supports a flush input so an exception in a younger stage can abort an in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width; any even value ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  issue request; sampled only in IDLE
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved (start ignored)
- src_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  input  WIDTH  rt operand (divisor / multiplier)
- flush  input  1  abort in-flight op, drop a same-cycle start
- busy  output  1  high while an iterative op is in flight
- done  output  1  one-cycle pulse: HI/LO just updated by an iterative op
- hi  output  WIDTH  HI register (remainder / upper product)
- lo  output  WIDTH  LO register (quotient / lower product)

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts immediately with no HI/LO update.
- States: IDLE → CALC → FIN → IDLE. busy = (state==CALC || state==FIN). done is registered.
- IDLE, start=1, flush=0, op=MTHI/MTLO: hi (resp. lo) ← src_a at this edge. State stays IDLE, no done.
- IDLE, start=1, flush=0, op∈{MULT,MULTU,DIV,DIVU}: accept edge E0.
  - Latch operands; for signed ops latch magnitudes plus result sign flags.
  - Clear counter; go to CALC.
- CALC: one iteration per edge, WIDTH iterations at E1..E_WIDTH, then go to FIN.
  - Multiply: shift-add, 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
- FIN, at edge E_WIDTH+1:
  - Apply sign fix: the product is negated if the operand signs differ. The quotient is negated if the signs differ. The remainder takes the sign of the dividend.
  - Write {hi,lo}; go to IDLE; done=1 for exactly the following cycle.
- Latency: accept at E0, results visible and done=1 after E0+WIDTH+1. busy drops in the same cycle done rises.
- Back-to-back: a start in the done cycle is accepted, since the state is IDLE.
- start while busy: ignored, no queuing. The issuing stage must stall on busy.
- flush=1 at any edge while busy: go to IDLE, HI/LO unchanged, no done.
- flush=1 with start in IDLE: start dropped, including MTHI/MTLO. flush outranks start; reset outranks all.
- Divisor zero (DIV or DIVU): full latency; hi=src_a as latched, lo=all ones. Identical for signed and unsigned.
- Signed overflow (−2^(WIDTH−1) / −1): lo=−2^(WIDTH−1) (wraps), hi=0.
- Arithmetic:
  - MULT: two's-complement 2·WIDTH product.
  - MULTU: unsigned 2·WIDTH product.
  - DIV truncates toward zero.
  - All internal sums are WIDTH+1 bits; no overflow flag is produced.
- hi/lo hold their values in all other cycles. Reserved op codes are ignored.

Decomposition:
- Shared package mdu_pkg: op code constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO) and state encoding (IDLE, CALC, FIN). The decoder uses the same op constants.
- One natural sub-module: mdu_div_step, the combinational single restoring-divide iteration. Inputs are partial remainder, dividend bit and divisor; outputs are the next remainder and the quotient bit. It is instantiated once in the CALC datapath.
- Sign handling and the shift-add path stay inline.

Test Plan:
- MULT src_a=FFFFFFFD (−3), src_b=5: done exactly 33 edges after the accept edge; hi=FFFFFFFF, lo=FFFFFFF1. busy high for exactly 33 cycles.
- MULTU FFFFFFFF×FFFFFFFF: hi=FFFFFFFE, lo=00000001. Then DIVU 100/7, started in the done cycle: lo=0000000E, hi=00000002.
- DIV −7/2 gives lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF gives lo=80000000, hi=0.
- DIVU 5/0 gives hi=00000005, lo=FFFFFFFF. DIV FFFFFFF9/0 gives hi=FFFFFFF9, lo=FFFFFFFF.
- Abort cases, starting from hi=lo=12345678:
  - flush asserted 10 cycles into a DIV: busy=0 next cycle, no done pulse, hi/lo stay 12345678.
  - start+flush together in IDLE: nothing accepted.
- MTHI src_a=AAAA5555 in IDLE: hi=AAAA5555 next cycle, no done.
- MTLO or MULT issued while busy: ignored, in-flight result unaffected.
- reset mid-CALC: all outputs 0 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared op codes and FSM state encoding for the multiply/divide
//            unit and the instruction decoder that feeds it.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Op codes on the 3-bit op bus; 110/111 are reserved and ignored.
    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    // Controller states: IDLE accepts work, CALC iterates, FIN writes HI/LO.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } mdu_state_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_step
// Brief    : One combinational restoring-division iteration. Shifts the next
//            dividend bit into the partial remainder, and subtracts the
//            divisor when the subtraction does not go negative.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dividend_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_partial;
    logic [WIDTH:0] w_diff;

    // Trial subtraction on WIDTH+1 bits. Both the kept and the restored result
    // are smaller than the divisor, so they always fit back into WIDTH bits.
    always_comb begin
        w_partial  = {i_rem, i_dividend_bit};
        w_diff     = w_partial - {1'b0, i_divisor};
        o_q_bit    = (w_partial >= {1'b0, i_divisor});
        o_rem_next = o_q_bit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
    end

endmodule : mdu_div_step
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
//            Signed ops run on magnitudes, and the sign is fixed up in FIN.
//            MTHI/MTLO write in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    mdu_state_t          r_state;
    mdu_state_t          w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic                r_neg_res;    // product / quotient must be negated
    logic                r_neg_rem;    // remainder takes the dividend's sign
    logic                r_div_zero;
    logic [WIDTH-1:0]    r_opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]    r_a_raw;      // dividend as issued, for divide-by-zero
    logic [2*WIDTH-1:0]  r_acc;        // {upper/remainder, lower/quotient}
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_done;

    logic                w_issue;
    logic                w_accept;
    logic                w_mthi;
    logic                w_mtlo;
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic                w_op_div;
    logic [WIDTH:0]      w_mul_sum;
    logic [2*WIDTH-1:0]  w_mul_next;
    logic [WIDTH-1:0]    w_rem_next;
    logic                w_q_bit;
    logic [2*WIDTH-1:0]  w_div_next;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_res_hi;
    logic [WIDTH-1:0]    w_res_lo;

    // Issue decode and operand conditioning. flush suppresses any issue.
    always_comb begin
        w_issue  = (r_state == IDLE) && start && !flush;
        w_accept = w_issue && !op[2];
        w_mthi   = w_issue && (op == MDU_MTHI);
        w_mtlo   = w_issue && (op == MDU_MTLO);
        w_signed = (op == MDU_MULT) || (op == MDU_DIV);
        w_op_div = (op == MDU_DIV) || (op == MDU_DIVU);
        w_a_neg  = w_signed && src_a[WIDTH-1];
        w_b_neg  = w_signed && src_b[WIDTH-1];
        w_a_mag  = w_a_neg ? -src_a : src_a;
        w_b_mag  = w_b_neg ? -src_b : src_b;
    end

    // Shift-add step: the low half holds the multiplier, which is consumed
    // LSB first, and the WIDTH+1-bit sum shifts into the top of the accumulator.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem          (r_acc[2*WIDTH-1:WIDTH]),
        .i_dividend_bit (r_acc[WIDTH-1]),
        .i_divisor      (r_opnd),
        .o_rem_next     (w_rem_next),
        .o_q_bit        (w_q_bit)
    );

    // Restoring divide: dividend bits shift out of the top of the low half and
    // quotient bits shift in at the bottom.
    always_comb begin
        w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};
    end

    // Final sign fix-up and the special case for a zero divisor.
    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_res_hi = r_a_raw;
                w_res_lo = {WIDTH{1'b1}};
            end else begin
                w_res_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                w_res_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            end
        end
    end

    // Next-state logic: flush aborts from any busy state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_next = CALC;
            CALC: begin
                if (flush)                w_state_next = IDLE;
                else if (r_cnt == c_last) w_state_next = FIN;
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Datapath, HI/LO, and the registered done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= '0;
            r_a_raw    <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == FIN) && !flush;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_is_div   <= w_op_div;
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= (src_b == '0);
                        r_a_raw    <= src_a;
                        r_opnd     <= w_op_div ? w_b_mag : w_a_mag;
                        r_acc      <= {{WIDTH{1'b0}}, (w_op_div ? w_a_mag : w_b_mag)};
                    end else if (w_mthi) begin
                        r_hi <= src_a;
                    end else if (w_mtlo) begin
                        r_lo <= src_a;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    if (!flush) begin
                        r_hi <= w_res_hi;
                        r_lo <= w_res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == CALC) || (r_state == FIN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Self-checking bench for mul_div_unit. It runs a table of directed
//            vectors, then randomized ops compared against an arithmetic
//            reference model, then hand sequences for the abort, flush,
//            busy-ignore and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks;
    int n_fail;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Expected {hi,lo} from plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (o)
            MDU_MULT:  res = 64'(sa * sb);
            MDU_MULTU: res = {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Drives one request for a single edge and returns at #1 after that edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    // Waits, with a bound, for done. It counts the edges since the previous
    // sample and the busy cycles seen before done.
    task automatic wait_done(input string name, output int lat, output int busy_cnt);
        bit ok;
        ok       = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: done not seen within 100 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        int bc;
        issue(o, a, b, 1'b0);
        wait_done(name, lat, bc);
        chk({name, " latency"}, 64'(lat), 64'(LAT));
        chk({name, " busy cycles"}, 64'(bc), 64'(LAT));
        chk({name, " busy low at done"}, 64'(busy), 64'd0);
        chk({name, " hi"}, 64'(hi), 64'(ehi));
        chk({name, " lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        int          lat;
        int          bc;
        int          dones;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        src_a    = '0;
        src_b    = '0;
        flush    = 1'b0;

        vecs[0] = '{"mult_neg3x5",   MDU_MULT,  32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{"multu_max",     MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"divu_100_7",    MDU_DIVU,  32'd100,       32'd7,         32'h2,         32'hE};
        vecs[3] = '{"div_neg7_2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{"div_overflow",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5] = '{"divu_by_zero",  MDU_DIVU,  32'd5,         32'd0,         32'h5,         32'hFFFF_FFFF};
        vecs[6] = '{"div_by_zero",   MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{"mult_7xneg2",   MDU_MULT,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};
        vecs[8] = '{"div_7_neg2",    MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);

        // Directed table, with done required to fall after one cycle.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " done one cycle"}, 64'(done), 64'd0);
        end

        // Back-to-back: DIVU is issued in the done cycle of the MULTU.
        run_op("b2b multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run_op("b2b divu",  MDU_DIVU,  32'd100, 32'd7, 32'h2, 32'hE);

        // Random ops against the reference model, issued back-to-back.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'($urandom_range(1, 9)) ^ {32{ra[0]}};
                default: ;
            endcase
            exp = ref_model(ro, ra, rb);
            run_op($sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb), ro, ra, rb,
                   exp[63:32], exp[31:0]);
        end

        // MTHI: single-cycle write, with no done pulse.
        issue(MDU_MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
        chk("mthi hi", 64'(hi), 64'hAAAA_5555);
        chk("mthi done", 64'(done), 64'd0);
        chk("mthi busy", 64'(busy), 64'd0);

        // Flush 10 cycles into a DIV leaves HI/LO untouched.
        issue(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        issue(MDU_MTLO, 32'h1234_5678, 32'd0, 1'b0);
        issue(MDU_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        chk("flush no done", 64'(dones), 64'd0);
        chk("flush hi", 64'(hi), 64'h1234_5678);
        chk("flush lo", 64'(lo), 64'h1234_5678);

        // start+flush in IDLE is dropped, including MTHI.
        issue(MDU_MULT, 32'd5, 32'd5, 1'b1);
        chk("start+flush busy", 64'(busy), 64'd0);
        issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        chk("mthi+flush hi", 64'(hi), 64'h1234_5678);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("start+flush no done", 64'(dones), 64'd0);
        chk("start+flush lo", 64'(lo), 64'h1234_5678);

        // MTLO and MULT issued while busy are ignored.
        issue(MDU_MULT, 32'h1234, 32'h10, 1'b0);
        repeat (5) @(posedge clk);
        issue(MDU_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        issue(MDU_MULT, 32'd3, 32'd3, 1'b0);
        wait_done("busy ignore", lat, bc);
        chk("busy ignore latency", 64'(lat), 64'(LAT - 7));
        chk("busy ignore hi", 64'(hi), 64'h0);
        chk("busy ignore lo", 64'(lo), 64'h0001_2340);

        // Reset in mid-CALC clears everything.
        issue(MDU_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0);
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset done", 64'(done), 64'd0);
        chk("mid reset hi", 64'(hi), 64'd0);
        chk("mid reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mul_div_unit
`default_nettype wire
